// File: rtl/cpu_defs.sv
// Shared CPU type definitions: stall vector, instruction address and controller state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_defs;

    typedef logic        Bit_t;
    typedef logic [31:0] InstAddr_t;

    // MSB is the most upstream stage. A request from stage k sets the bit
    // for k and for every stage before it.
    typedef struct packed {
        Bit_t stall_if;
        Bit_t stall_id;
        Bit_t stall_ex;
        Bit_t stall_mem;
        Bit_t stall_wb;
    } Stall_t;

    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_MULTI,
        CTRL_FLUSH
    } CtrlState_t;

    localparam Stall_t STALL_NONE = 5'b00000;
    localparam Stall_t STALL_ID   = 5'b11000;
    localparam Stall_t STALL_EX   = 5'b11100;
    localparam Stall_t STALL_MEM  = 5'b11110;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush control bundle between the pipeline stages and the sequencer.
// Latency: n/a (wiring only).
// Backpressure: n/a; the stall vector itself is the backpressure to the stages.
//   master: pipeline side, drives hazard/exception requests, consumes stall/flush.
//   slave : sequencer side, consumes requests, drives stall/flush/flush_pc/ex_mc_done.
interface pipeline_ctrl_if #(
    parameter int CNT_WIDTH = 6
) ();
    import cpu_defs::*;

    Bit_t                 id_load_use;
    Bit_t                 ex_mc_start;
    logic [CNT_WIDTH-1:0] ex_mc_cycles;
    Bit_t                 mem_busy;
    Bit_t                 exception_valid;
    InstAddr_t            exception_target;

    Stall_t               stall;
    Bit_t                 flush;
    InstAddr_t            flush_pc;
    Bit_t                 ex_mc_done;

    modport master (
        output id_load_use, ex_mc_start, ex_mc_cycles, mem_busy,
               exception_valid, exception_target,
        input  stall, flush, flush_pc, ex_mc_done
    );

    modport slave (
        input  id_load_use, ex_mc_start, ex_mc_cycles, mem_busy,
               exception_valid, exception_target,
        output stall, flush, flush_pc, ex_mc_done
    );

endinterface

// File: rtl/pipeline_ctrl_mc_counter.sv
// Loadable down-counter that times multi-cycle EX ops; floors at 1 and flags ==1.
// Latency: load/clear/decrement take effect on the next clk edge; is_one is combinational.
// Backpressure: none; the owner holds the count at 1 by simply not finishing the op.
//   ports: clk, rst, clr, load, load_val, dec -> is_one
module pipeline_ctrl_mc_counter #(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 is_one
);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt > CNT_WIDTH'(1))) begin
            // Never decrements below 1: the final cycle is held until MEM frees up.
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    assign is_one = (cnt == CNT_WIDTH'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges ID/EX/MEM stall requests, times multi-cycle EX ops, turns exceptions into a flush.
// Latency: stall and ex_mc_done are combinational; flush/flush_pc appear the cycle after exception_valid.
// Backpressure: priority exception > mem_busy > EX multi-cycle > load-use; stall_wb never asserts.
//   ports: clk, rst (sync, active-high), bus (pipeline_ctrl_if.slave)
module pipeline_ctrl
    import cpu_defs::*;
#(
    parameter int CNT_WIDTH = 6
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);

    CtrlState_t state;
    CtrlState_t state_nxt;
    Bit_t       flush_q;
    InstAddr_t  flush_pc_q;

    Stall_t     stall_c;
    Bit_t       done_c;
    logic       cnt_clr;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_is_one;
    logic       mc_long;

    logic [CNT_WIDTH-1:0] cnt_load_val;

    // An op of length N stalls EX for N-1 cycles, so the counter starts at N-1
    // and the op completes in the cycle the counter reads 1.
    assign cnt_load_val = bus.ex_mc_cycles - CNT_WIDTH'(1);
    assign mc_long      = (bus.ex_mc_cycles > CNT_WIDTH'(1));

    pipeline_ctrl_mc_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_mc_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        stall_c   = STALL_NONE;
        done_c    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        state_nxt = state;

        case (state)
            CTRL_FLUSH: begin
                // Stage registers are being cleared; any new exception is ignored.
                state_nxt = CTRL_RUN;
            end

            CTRL_RUN: begin
                if (bus.exception_valid) begin
                    cnt_clr   = 1'b1;
                    state_nxt = CTRL_FLUSH;
                end else if (bus.mem_busy) begin
                    // EX is frozen too, so a start presented now is not taken;
                    // EX keeps presenting it until MEM releases the pipeline.
                    stall_c = STALL_MEM;
                end else if (bus.ex_mc_start) begin
                    if (mc_long) begin
                        stall_c   = STALL_EX;
                        cnt_load  = 1'b1;
                        state_nxt = CTRL_MULTI;
                    end else begin
                        done_c = 1'b1;
                        if (bus.id_load_use) begin
                            stall_c = STALL_ID;
                        end
                    end
                end else if (bus.id_load_use) begin
                    stall_c = STALL_ID;
                end
            end

            CTRL_MULTI: begin
                if (bus.exception_valid) begin
                    // Abort the op silently: no done pulse.
                    cnt_clr   = 1'b1;
                    state_nxt = CTRL_FLUSH;
                end else if (!cnt_is_one) begin
                    // Keep timing the op even while MEM holds the pipe.
                    stall_c = bus.mem_busy ? STALL_MEM : STALL_EX;
                    cnt_dec = 1'b1;
                end else if (bus.mem_busy) begin
                    stall_c = STALL_MEM;
                end else begin
                    done_c    = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = CTRL_RUN;
                    // EX advances this cycle, so a load-use hazard is visible again.
                    if (bus.id_load_use) begin
                        stall_c = STALL_ID;
                    end
                end
            end

            default: begin
                cnt_clr   = 1'b1;
                state_nxt = CTRL_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CTRL_RUN;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            state   <= state_nxt;
            flush_q <= (state_nxt == CTRL_FLUSH);
            if ((state != CTRL_FLUSH) && bus.exception_valid) begin
                flush_pc_q <= bus.exception_target;
            end
        end
    end

    assign bus.stall      = stall_c;
    assign bus.ex_mc_done = done_c;
    assign bus.flush      = flush_q;
    assign bus.flush_pc   = flush_pc_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Latency: inputs change on the falling edge, outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_pipeline_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipeline_ctrl_if #(.CNT_WIDTH(6)) bus ();

    pipeline_ctrl #(
        .CNT_WIDTH (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one cycle of inputs after the falling edge, then let combinational outputs settle.
    task automatic drive(input logic lu, input logic st, input logic [5:0] n,
                         input logic mb, input logic ev, input logic [31:0] tgt);
        @(negedge clk);
        bus.id_load_use      = lu;
        bus.ex_mc_start      = st;
        bus.ex_mc_cycles     = n;
        bus.mem_busy         = mb;
        bus.exception_valid  = ev;
        bus.exception_target = tgt;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic expect_outs(input string tag, input logic [4:0] st, input logic dn, input logic fl);
        check_eq({tag, ".stall"}, 32'(bus.stall), 32'(st));
        check_eq({tag, ".done"},  32'(bus.ex_mc_done), 32'(dn));
        check_eq({tag, ".flush"}, 32'(bus.flush), 32'(fl));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.id_load_use      = 1'b0;
        bus.ex_mc_start      = 1'b0;
        bus.ex_mc_cycles     = 6'd0;
        bus.mem_busy         = 1'b0;
        bus.exception_valid  = 1'b0;
        bus.exception_target = 32'h0;

        // Reset state
        idle();
        idle();
        expect_outs("rst", 5'b00000, 1'b0, 1'b0);
        check_eq("rst.flush_pc", bus.flush_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        expect_outs("rst_rel", 5'b00000, 1'b0, 1'b0);

        // Load-use for a single cycle
        drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
        expect_outs("lu.t0", 5'b11000, 1'b0, 1'b0);
        idle();
        expect_outs("lu.t1", 5'b00000, 1'b0, 1'b0);

        // N=4: EX stalled t..t+2, done at t+3
        drive(1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 32'h0);
        expect_outs("n4.t0", 5'b11100, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
        expect_outs("n4.t1_lu", 5'b11100, 1'b0, 1'b0);
        idle();
        expect_outs("n4.t2", 5'b11100, 1'b0, 1'b0);
        idle();
        expect_outs("n4.t3", 5'b00000, 1'b1, 1'b0);
        idle();
        expect_outs("n4.t4", 5'b00000, 1'b0, 1'b0);

        // N=1 and N=0 finish in the same cycle without stalling
        drive(1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 32'h0);
        expect_outs("n1.t0", 5'b00000, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h0);
        expect_outs("n0.t0", 5'b00000, 1'b1, 1'b0);
        idle();
        expect_outs("n1.t1", 5'b00000, 1'b0, 1'b0);

        // N=3 with mem_busy t+1..t+3: done withheld until t+4
        drive(1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 32'h0);
        expect_outs("n3mb.t0", 5'b11100, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
            expect_outs($sformatf("n3mb.t%0d", i), 5'b11110, 1'b0, 1'b0);
        end
        idle();
        expect_outs("n3mb.t4", 5'b00000, 1'b1, 1'b0);
        idle();
        expect_outs("n3mb.t5", 5'b00000, 1'b0, 1'b0);

        // ex_mc_start during MULTI is ignored: N=3 still finishes at t+2
        drive(1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 32'h0);
        expect_outs("mcign.t0", 5'b11100, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 6'd10, 1'b0, 1'b0, 32'h0);
        expect_outs("mcign.t1", 5'b11100, 1'b0, 1'b0);
        idle();
        expect_outs("mcign.t2", 5'b00000, 1'b1, 1'b0);

        // Exception at t+1 of an N=5 op
        drive(1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 32'h0);
        expect_outs("exc.t0", 5'b11100, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'hBFC00380);
        expect_outs("exc.t1", 5'b00000, 1'b0, 1'b0);
        // Second exception while flushing must be ignored
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h12345678);
        expect_outs("exc.t2", 5'b00000, 1'b0, 1'b1);
        check_eq("exc.t2.flush_pc", bus.flush_pc, 32'hBFC00380);
        // Back in RUN: a load-use stalls only IF/ID, proving MULTI was aborted
        drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
        expect_outs("exc.t3", 5'b11000, 1'b0, 1'b0);
        for (int i = 4; i <= 7; i++) begin
            idle();
            expect_outs($sformatf("exc.t%0d", i), 5'b00000, 1'b0, 1'b0);
        end

        // Exception beats mem_busy and load-use
        drive(1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 32'h80001000);
        expect_outs("prio.t0", 5'b00000, 1'b0, 1'b0);
        idle();
        expect_outs("prio.t1", 5'b00000, 1'b0, 1'b1);
        check_eq("prio.t1.flush_pc", bus.flush_pc, 32'h80001000);
        idle();
        expect_outs("prio.t2", 5'b00000, 1'b0, 1'b0);

        // mem_busy in RUN stalls through MEM
        drive(1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
        expect_outs("mb.run", 5'b11110, 1'b0, 1'b0);

        // Synchronous reset in the middle of an N=6 op
        drive(1'b0, 1'b1, 6'd6, 1'b0, 1'b0, 32'h0);
        expect_outs("rstmc.t0", 5'b11100, 1'b0, 1'b0);
        idle();
        expect_outs("rstmc.t1", 5'b11100, 1'b0, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int i = 3; i <= 8; i++) begin
            idle();
            expect_outs($sformatf("rstmc.t%0d", i), 5'b00000, 1'b0, 1'b0);
        end
        check_eq("rstmc.flush_pc", bus.flush_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
